// File: rtl/pfifo_axis_pkg.sv
// Shared types and constants for the pixel-FIFO to AXI4-Stream video bridge.
package pfifo_axis_pkg;

  typedef enum logic {SYNC = 1'b0, STREAM = 1'b1} state_e;

  localparam int WORD_W   = 34;
  localparam int PIX_W    = 24;
  localparam int SOF_BIT  = 32;
  localparam int LAST_BIT = 33;

  localparam int R_HI = 23, R_LO = 16;
  localparam int G_HI = 15, G_LO = 8;
  localparam int B_HI = 7,  B_LO = 0;

  // 26-bit buffer payload {tuser, tlast, tdata}
  typedef struct packed {
    logic             tuser;
    logic             tlast;
    logic [PIX_W-1:0] tdata;
  } beat_t;

  function automatic logic [PIX_W-1:0] word_rgb(input logic [WORD_W-1:0] w);
    return {w[R_HI:R_LO], w[G_HI:G_LO], w[B_HI:B_LO]};
  endfunction

endpackage

// File: rtl/pfifo_axis_video_out_if.sv
// FIFO read port plus AXI4-Stream video master, bundled for the bridge.
interface pfifo_axis_video_out_if;
  logic                                pfifo_rd_en;
  logic [pfifo_axis_pkg::WORD_W-1:0]   pfifo_dout;
  logic                                pfifo_empty;
  logic [pfifo_axis_pkg::PIX_W-1:0]    m_axis_tdata;
  logic                                m_axis_tvalid;
  logic                                m_axis_tready;
  logic                                m_axis_tuser;
  logic                                m_axis_tlast;

  modport master (
    output pfifo_rd_en, input pfifo_dout, input pfifo_empty,
    output m_axis_tdata, output m_axis_tvalid, output m_axis_tuser, output m_axis_tlast,
    input  m_axis_tready
  );

  modport slave (
    input  pfifo_rd_en, output pfifo_dout, output pfifo_empty,
    input  m_axis_tdata, input m_axis_tvalid, input m_axis_tuser, input m_axis_tlast,
    output m_axis_tready
  );
endinterface

// File: rtl/pfifo_axis_video_out_skid.sv
// Two-entry output buffer with registered AXIS outputs; the upstream read-issue
// logic guarantees it is never pushed while full.
module axis_skid_buffer
  import pfifo_axis_pkg::*;
(
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       push_i,
  input  beat_t      din_i,
  input  logic       ready_i,
  output logic       valid_o,
  output beat_t      dout_o,
  output logic [1:0] occ_o
);

  logic  out_vld_q, skid_vld_q;
  beat_t out_q, skid_q;
  logic  pop;

  assign pop     = out_vld_q && ready_i;
  assign valid_o = out_vld_q;
  assign dout_o  = out_q;
  // Occupancy net of this cycle's pop, so a full-rate stream keeps issuing reads.
  assign occ_o   = {1'b0, out_vld_q} + {1'b0, skid_vld_q} - {1'b0, pop};

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      out_q      <= '0;
      skid_q     <= '0;
    end else if (!out_vld_q || pop) begin
      if (skid_vld_q) begin
        out_q      <= skid_q;
        out_vld_q  <= 1'b1;
        skid_vld_q <= push_i;
        if (push_i) skid_q <= din_i;
      end else begin
        out_vld_q <= push_i;
        if (push_i) out_q <= din_i;
      end
    end else if (push_i) begin
      skid_q     <= din_i;
      skid_vld_q <= 1'b1;
    end
  end

endmodule

// File: rtl/pfifo_axis_video_out.sv
// Pixel FIFO to AXI4-Stream video: SOF sync, x/y tracking with SOF error
// detection, frame stats, and read throttling against a 2-entry output buffer.
module pfifo_axis_video_out
  import pfifo_axis_pkg::*;
#(
  parameter int H_ACTIVE = 800,
  parameter int V_ACTIVE = 600
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  pfifo_axis_video_out_if.master        bus,
  input  logic                          enable,
  output logic                          frame_done,
  output logic [15:0]                   frame_count,
  output logic                          err_sof_early,
  output logic                          err_sof_late,
  input  logic                          err_clear
);

  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

  state_e          state_q, state_d;
  logic [XW-1:0]   x_q, x_d, cx;
  logic [YW-1:0]   y_q, y_d, cy, oy_q, oy_base;
  logic            run_q, rd_pend_q;
  logic            err_early_q, err_late_q, set_early, set_late;
  logic [15:0]     fcnt_q;
  logic            push, sof, at_origin, fire;
  beat_t           push_beat, out_beat;
  logic            out_vld;
  logic [1:0]      occ;
  logic            unused_bits;

  assign unused_bits = ^{bus.pfifo_dout[LAST_BIT], bus.pfifo_dout[31:24]};
  assign sof         = bus.pfifo_dout[SOF_BIT];
  assign at_origin   = (x_q == '0) && (y_q == '0);

  // run_q holds reads off during and just after reset.
  assign bus.pfifo_rd_en = run_q && !bus.pfifo_empty &&
                           (({1'b0, occ} + {2'b0, rd_pend_q}) < 3'd2);

  always_comb begin
    push      = 1'b0;
    push_beat = '0;
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    cx        = x_q;
    cy        = y_q;
    set_early = 1'b0;
    set_late  = 1'b0;
    if (rd_pend_q) begin
      case (state_q)
        SYNC: if (sof && enable) begin
          push = 1'b1;
          cx   = '0;
          cy   = '0;
        end
        STREAM: if (!sof && at_origin) begin
          set_late = 1'b1;
          state_d  = SYNC;
        end else begin
          push = 1'b1;
          if (sof && !at_origin) begin
            set_early = 1'b1;
            cx        = '0;
            cy        = '0;
          end
        end
        default: state_d = SYNC;
      endcase
    end
    if (push) begin
      push_beat.tuser = sof;
      push_beat.tlast = (cx == X_LAST);
      push_beat.tdata = word_rgb(bus.pfifo_dout);
      state_d         = STREAM;
      if (cx == X_LAST) begin
        x_d = '0;
        if (cy == Y_LAST) begin
          y_d     = '0;
          // enable only matters at frame boundaries
          state_d = enable ? STREAM : SYNC;
        end else begin
          y_d = cy + 1'b1;
        end
      end else begin
        x_d = cx + 1'b1;
        y_d = cy;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= SYNC;
      x_q         <= '0;
      y_q         <= '0;
      run_q       <= 1'b0;
      rd_pend_q   <= 1'b0;
      err_early_q <= 1'b0;
      err_late_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      run_q       <= 1'b1;
      rd_pend_q   <= bus.pfifo_rd_en;
      err_early_q <= set_early ? 1'b1 : (err_clear ? 1'b0 : err_early_q);
      err_late_q  <= set_late  ? 1'b1 : (err_clear ? 1'b0 : err_late_q);
    end
  end

  axis_skid_buffer u_skid (
    .aclk    (aclk),
    .aresetn (aresetn),
    .push_i  (push),
    .din_i   (push_beat),
    .ready_i (bus.m_axis_tready),
    .valid_o (out_vld),
    .dout_o  (out_beat),
    .occ_o   (occ)
  );

  // Output-side line tracking lets frame_done land on the accepted tlast beat.
  assign fire       = out_vld && bus.m_axis_tready;
  assign oy_base    = out_beat.tuser ? '0 : oy_q;
  assign frame_done = fire && out_beat.tlast && (oy_base == Y_LAST);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      oy_q   <= '0;
      fcnt_q <= '0;
    end else if (fire) begin
      if (out_beat.tlast) oy_q <= frame_done ? '0 : oy_base + 1'b1;
      else                oy_q <= oy_base;
      if (frame_done) fcnt_q <= fcnt_q + 16'd1;
    end
  end

  assign bus.m_axis_tvalid = out_vld;
  assign bus.m_axis_tdata  = out_beat.tdata;
  assign bus.m_axis_tuser  = out_beat.tuser;
  assign bus.m_axis_tlast  = out_beat.tlast;
  assign frame_count       = fcnt_q;
  assign err_sof_early     = err_early_q;
  assign err_sof_late      = err_late_q;

endmodule
